// File: rtl/jtag_catch_drain.sv
// Drains one JTAG capture into a framed valid/ready packet: header word
// {IR, trunc, 7'b0, DATALEN} followed by the captured RAM words.
module jtag_catch_drain #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 512,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              int_register_i,
  input  logic [7:0]        IR_register_i,
  input  logic [15:0]       DATALEN_register_i,
  output logic              clear_int_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [31:0]       m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic [15:0]       frames_o
);

  typedef enum logic [2:0] {IDLE, HDR, RD, WAIT, SEND, CLR, WAITLOW} state_t;

  state_t      state, nxt;
  logic [7:0]  ir;
  logic [15:0] len;
  logic        trunc;
  logic [16:0] words, idx, raw_words;
  logic [31:0] dout;
  logic [1:0]  lat;
  logic [15:0] frames;
  logic        start, accept, last_data, lat_done;

  // 17-bit so DATALEN=0xFFFF rounds up without overflow
  assign raw_words = (17'(DATALEN_register_i) + 17'd31) >> 5;
  assign start     = (state == IDLE) && enable_i && int_register_i;
  assign accept    = m_valid_o && m_ready_i;
  assign last_data = (idx == words - 17'd1);
  assign lat_done  = (lat == 2'(RD_LAT - 1));

  always_comb begin
    nxt       = state;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    case (state)
      IDLE:    if (start) nxt = HDR;
      HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = {ir, trunc, 7'b0, len};
        m_last_o  = (words == 17'd0);
        if (accept) nxt = (words == 17'd0) ? CLR : RD;
      end
      RD:      nxt = WAIT;
      WAIT:    if (lat_done) nxt = SEND;
      SEND: begin
        m_valid_o = 1'b1;
        m_data_o  = dout;
        m_last_o  = last_data;
        if (accept) nxt = last_data ? CLR : RD;
      end
      CLR:     nxt = WAITLOW;
      // a stale flag must fall before another capture is accepted
      WAITLOW: if (!int_register_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ir     <= '0;
      len    <= '0;
      trunc  <= 1'b0;
      words  <= '0;
      idx    <= '0;
      dout   <= '0;
      lat    <= '0;
      frames <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        ir    <= IR_register_i;
        len   <= DATALEN_register_i;
        trunc <= (raw_words > 17'(DEPTH));
        words <= (raw_words > 17'(DEPTH)) ? 17'(DEPTH) : raw_words;
        idx   <= '0;
      end
      if (state == RD) lat <= '0;
      if (state == WAIT) begin
        lat <= lat + 2'd1;
        if (lat_done) dout <= ram_rdata_i;
      end
      if (state == SEND && accept) idx <= idx + 17'd1;
      if (state == CLR) frames <= frames + 16'd1;
    end
  end

  assign clear_int_o = (state == CLR);
  assign busy_o      = (state != IDLE);
  assign ram_raddr_o = ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];
  assign frames_o    = frames;

endmodule

// File: tb/tb_jtag_catch_drain.sv
// Directed bench for jtag_catch_drain with a 1-cycle-latency RAM model.
module tb_jtag_catch_drain;

  logic        sclk = 1'b0;
  logic        reset;
  logic        enable_i, int_register_i, m_ready_i;
  logic [7:0]  IR_register_i;
  logic [15:0] DATALEN_register_i;
  logic        clear_int_o, m_valid_o, m_last_o, busy_o;
  logic [9:0]  ram_raddr_o;
  logic [31:0] ram_rdata_i, m_data_o;
  logic [15:0] frames_o;

  logic [31:0] mem   [0:1023];
  logic [31:0] exp_w [0:599];
  int passed = 0, total = 0;
  int beats, clears;

  always #5 sclk = ~sclk;
  always @(posedge sclk) ram_rdata_i <= mem[ram_raddr_o];

  jtag_catch_drain dut (
    .sclk(sclk), .reset(reset), .enable_i(enable_i), .int_register_i(int_register_i),
    .IR_register_i(IR_register_i), .DATALEN_register_i(DATALEN_register_i),
    .clear_int_o(clear_int_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .busy_o(busy_o), .frames_o(frames_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_pkt(input logic [7:0] ir, input logic [15:0] len);
    @(negedge sclk);
    IR_register_i = ir; DATALEN_register_i = len;
    int_register_i = 1'b1; enable_i = 1'b1;
  endtask

  // accepts n beats, checking each against exp_w and m_data stability under stall
  task automatic drain(input int n, input bit toggle);
    int cyc = 0;
    bit hold = 0;
    logic [31:0] held = '0;
    beats = 0;
    while (beats < n && cyc < 5000) begin
      @(negedge sclk);
      m_ready_i = toggle ? ~m_ready_i : 1'b1;
      #1;
      if (hold) chk("stall_hold", {m_valid_o, m_data_o}, {1'b1, held});
      hold = 0;
      if (m_valid_o && m_ready_i) begin
        chk($sformatf("beat%0d_data", beats), m_data_o, exp_w[beats]);
        chk($sformatf("beat%0d_last", beats), m_last_o, (beats == n - 1));
        beats++;
      end else if (m_valid_o) begin
        hold = 1; held = m_data_o;
      end
      cyc++;
    end
    if (beats < n) begin
      total++;
      $error("FAIL drain_timeout observed=%0d expected=%0d", beats, n);
    end
  endtask

  task automatic watch_clear(input int cycles);
    clears = 0;
    repeat (cycles) begin
      @(negedge sclk); #1;
      if (clear_int_o) clears++;
    end
  endtask

  task automatic drop_int;
    @(negedge sclk); int_register_i = 1'b0;
    @(negedge sclk); #1;
    chk("back_to_idle", busy_o, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h1234_5678; mem[1] = 32'h0000_000A;
    reset = 1'b0; enable_i = 1'b0; int_register_i = 1'b0; m_ready_i = 1'b0;
    IR_register_i = '0; DATALEN_register_i = '0;
    #1;
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_clear", clear_int_o, 1'b0);
    chk("rst_frames", frames_o, 16'd0);
    chk("rst_raddr", ram_raddr_o, 10'd0);
    chk("rst_data", m_data_o, 32'd0);
    repeat (2) @(negedge sclk);
    reset = 1'b1;
    // ready high while idle must not start anything
    m_ready_i = 1'b1; enable_i = 1'b1;
    repeat (3) @(negedge sclk);
    #1 chk("idle_no_int", busy_o, 1'b0);

    // nominal 36-bit capture
    exp_w[0] = 32'h2500_0024; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'h0000_000A;
    start_pkt(8'h25, 16'd36);
    drain(3, 1'b0);
    watch_clear(4);
    chk("nom_clears", clears, 1);
    chk("nom_frames", frames_o, 16'd1);
    drop_int();

    // zero length: header only
    exp_w[0] = 32'h1100_0000;
    start_pkt(8'h11, 16'd0);
    drain(1, 1'b0);
    watch_clear(4);
    chk("zero_clears", clears, 1);
    chk("zero_frames", frames_o, 16'd2);
    chk("zero_raddr", ram_raddr_o, 10'd0);
    drop_int();

    // backpressure, with enable dropped mid-packet
    exp_w[0] = 32'h2500_0024; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'h0000_000A;
    start_pkt(8'h25, 16'd36);
    @(negedge sclk); enable_i = 1'b0; m_ready_i = 1'b0;
    drain(3, 1'b1);
    chk("bp_beats", beats, 3);
    watch_clear(4);
    chk("bp_clears", clears, 1);
    chk("bp_frames", frames_o, 16'd3);
    drop_int();
    enable_i = 1'b1;

    // re-trigger guard: stale flag held 20 cycles
    exp_w[0] = 32'h1100_0000;
    start_pkt(8'h11, 16'd0);
    drain(1, 1'b0);
    clears = 0; beats = 0;
    repeat (20) begin
      @(negedge sclk); #1;
      if (clear_int_o) clears++;
      if (m_valid_o) beats++;
    end
    chk("guard_clears", clears, 1);
    chk("guard_no_valid", beats, 0);
    chk("guard_frames", frames_o, 16'd4);
    chk("guard_busy", busy_o, 1'b1);
    drop_int();

    // truncation: 0xFFFF bits -> 2048 words clamped to 512
    exp_w[0] = 32'h3C80_FFFF;
    for (int i = 0; i < 512; i++) exp_w[i + 1] = mem[i];
    start_pkt(8'h3C, 16'hFFFF);
    drain(513, 1'b0);
    watch_clear(4);
    chk("trunc_clears", clears, 1);
    chk("trunc_frames", frames_o, 16'd5);
    drop_int();

    // reset during SEND of data word 1
    exp_w[0] = 32'h2500_0024; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'h0000_000A;
    start_pkt(8'h25, 16'd36);
    @(negedge sclk); m_ready_i = 1'b1;
    @(negedge sclk); m_ready_i = 1'b0;
    repeat (4) @(negedge sclk);
    #1;
    chk("pre_rst_send", {m_valid_o, m_data_o}, {1'b1, 32'h1234_5678});
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_data", m_data_o, 32'd0);
    chk("mid_rst_frames", frames_o, 16'd0);
    chk("mid_rst_clear", clear_int_o, 1'b0);
    @(negedge sclk); reset = 1'b1;
    drain(3, 1'b0);
    watch_clear(4);
    chk("rerun_clears", clears, 1);
    chk("rerun_frames", frames_o, 16'd1);
    drop_int();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtag_catch_drain.md
Name: jtag_catch_drain

Overview:
- Readout controller for the JTAG capture buffer.
- Waits for the capture logic's interrupt flag, then reads the latched IR and DATALEN registers.
- Walks the 32-bit capture RAM read port from BASE_ADDR and emits one framed packet (header word + data words) on a valid/ready stream.
- Pulses clear_int to re-arm capture. Sits between the JTAG catch block / capture RAM and the host-side stream sink.

Parameters:
- ADDR_W, 10, capture RAM read address width.
- DEPTH, 512, number of valid RAM words; payload is clamped to this.
- BASE_ADDR, 0, RAM address of the first captured word.
- RD_LAT, 1, RAM read latency in sclk cycles (1 or 2).

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_i  in  1  drain enable; sampled only in IDLE.
- int_register_i  in  1  capture-complete flag (level) from the catch block.
- IR_register_i  in  8  latched IR of the captured scan.
- DATALEN_register_i  in  16  captured DR length in bits.
- clear_int_o  out  1  one-cycle pulse clearing the catch block's interrupt.
- ram_raddr_o  out  ADDR_W  capture RAM read address.
- ram_rdata_i  in  32  capture RAM read data, valid RD_LAT cycles after the address.
- m_valid_o  out  1  stream word valid.
- m_ready_i  in  1  stream sink ready.
- m_data_o  out  32  stream word.
- m_last_o  out  1  final word of the packet.
- busy_o  out  1  high in any state other than IDLE.
- frames_o  out  16  count of completed packets; wraps 0xFFFF->0.

Behaviour:
- Reset values (async, reset=0): state IDLE; all outputs 0; ram_raddr_o=BASE_ADDR.
- Reset mid-packet: abandons the packet, no clear_int pulse, no frames_o increment.
- Word count: words = (DATALEN+31)>>5 (17-bit arithmetic, no overflow).
  - trunc = (words > DEPTH); if trunc, words = DEPTH.
- Header word: {IR[7:0], trunc, 7'b0, DATALEN[15:0]}.
  - IR and DATALEN are sampled once, in the IDLE->HDR cycle.
- State IDLE: leave only when enable_i=1 and int_register_i=1 in the same cycle; next state HDR.
- State HDR: m_valid_o=1, m_data_o=header, m_last_o=(words==0).
  - On accept (valid&ready): go to CLR if words==0, else RD.
- State RD: drive ram_raddr_o = BASE_ADDR + index (index starts at 0); go to WAIT.
- State WAIT: hold RD_LAT cycles, then register ram_rdata_i into the output register; go to SEND.
- State SEND: m_valid_o=1, m_last_o=(index==words-1).
  - m_data_o is held stable until accepted; m_valid_o never drops without an accept.
  - On accept: index+1, then RD, or CLR if last.
- Throughput: one data word per 2+RD_LAT cycles under a continuously ready sink.
- State CLR: clear_int_o=1 for exactly one cycle; frames_o increments; go to WAITLOW.
- State WAITLOW: stay until int_register_i=0, then IDLE. This prevents re-triggering on a stale flag.
- enable_i deasserted mid-packet: no effect; the current packet completes.
- Address wrap: BASE_ADDR+index is computed modulo 2^ADDR_W.
- m_ready_i may be high while m_valid_o is low; this has no effect.
- Valid and ready in the same cycle as the last beat count as the accept for that beat.

Test Plan:
- Nominal capture: IR=0x25, DATALEN=36, RAM[0]=0x12345678, RAM[1]=0xA, m_ready=1.
  -> stream 0x25000024, 0x12345678, 0x0000000A (m_last on third word).
  -> one clear_int_o pulse; frames_o=1.
- Zero length: DATALEN=0, IR=0x11 -> single word 0x11000000 with m_last=1, clear_int pulse, no RAM read issued.
- Backpressure: m_ready toggles 1/0 every cycle during the 36-bit case -> identical word sequence; m_data_o stable while m_valid_o=1 and m_ready_i=0; 3 accepts total.
- Truncation: DATALEN=0xFFFF, DEPTH=512 -> header bit23=1 (0x..80FFFF); exactly 512 data words, last from address 511; m_last on the 513th beat.
- Re-trigger guard: int_register_i held high 20 cycles after the clear_int pulse -> exactly one packet; a new packet starts only after int_register_i falls and rises again.
- Reset mid-packet: assert reset during the SEND of word 1 -> all outputs 0 immediately; frames_o=0; no clear_int pulse. After release with int_register_i=1, the full packet is re-sent from the header.
